// File: rtl/source_dat_gen_if.sv
// source_dat_gen_if: per-channel data/valid/ready/done bundle between the test-word source and its consumers.
interface source_dat_gen_if #(
    parameter int WIDTH = 16,
    parameter int N_CH  = 2
);
    logic [N_CH*WIDTH-1:0] dat_o;
    logic [N_CH-1:0]       dat_vld;
    logic [N_CH-1:0]       dat_rdy;
    logic [N_CH-1:0]       done;
    modport master (output dat_o, dat_vld, done, input dat_rdy);
    modport slave  (input dat_o, dat_vld, done, output dat_rdy);
endinterface

// File: rtl/source_dat_gen.sv
// source_dat_gen: N_CH independent test-word streams (const/incr/LFSR/rotl) with valid/ready handshake
// and an optional per-channel word limit that ends each run in a done state.
module source_dat_gen #(
    parameter int                        WIDTH   = 16,
    parameter int                        N_CH    = 2,
    parameter logic [N_CH*WIDTH-1:0]     SEEDS   = {16'h5678, 16'h1234},
    parameter logic [WIDTH-1:0]          POLY    = 16'hB400,
    parameter int                        N_WORDS = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic               load,
    output logic [1:0]         mode_q,
    source_dat_gen_if.master   bus
);
    localparam int CW = (N_WORDS > 0) ? $clog2(N_WORDS + 1) : 1;
    localparam logic RUN  = 1'b0;
    localparam logic DONE = 1'b1;

    // A zero seed would lock the LFSR, so every zero seed starts at 1 regardless of mode.
    function automatic logic [N_CH*WIDTH-1:0] guard(input logic [N_CH*WIDTH-1:0] s);
        guard = s;
        for (int i = 0; i < N_CH; i++)
            if (s[i*WIDTH +: WIDTH] == '0) guard[i*WIDTH +: WIDTH] = WIDTH'(1);
    endfunction

    localparam logic [N_CH*WIDTH-1:0] INIT = guard(SEEDS);

    function automatic logic [WIDTH-1:0] nxt(input logic [1:0] m, input logic [WIDTH-1:0] x);
        return (m == 2'd0) ? x :
               (m == 2'd1) ? x + WIDTH'(1) :
               (m == 2'd2) ? ((x >> 1) ^ (x[0] ? POLY : '0)) :
                             {x[WIDTH-2:0], x[WIDTH-1]};
    endfunction

    logic [N_CH*WIDTH-1:0] dat_q, dat_d;
    logic [N_CH-1:0]       st_q, st_d;
    logic [N_CH*CW-1:0]    cnt_q, cnt_d;
    logic [1:0]            mode_d;

    always_comb begin
        mode_d = load ? mode : mode_q;
        dat_d  = dat_q;
        st_d   = st_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < N_CH; i++) begin
            if (load) begin
                dat_d[i*WIDTH +: WIDTH] = INIT[i*WIDTH +: WIDTH];
                cnt_d[i*CW +: CW]       = '0;
                st_d[i]                 = RUN;
            end else if (st_q[i] == RUN && bus.dat_rdy[i]) begin
                if (N_WORDS != 0 && cnt_q[i*CW +: CW] == CW'(N_WORDS - 1)) begin
                    st_d[i] = DONE;
                end else begin
                    dat_d[i*WIDTH +: WIDTH] = nxt(mode_q, dat_q[i*WIDTH +: WIDTH]);
                    cnt_d[i*CW +: CW]       = (N_WORDS == 0) ? '0 : cnt_q[i*CW +: CW] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat_q  <= INIT;
            st_q   <= {N_CH{RUN}};
            cnt_q  <= '0;
            mode_q <= 2'd0;
        end else begin
            dat_q  <= dat_d;
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

    // The state flop doubles as the done flag; valid is its complement.
    assign bus.dat_o   = dat_q;
    assign bus.done    = st_q;
    assign bus.dat_vld = ~st_q;
endmodule

// File: tb/tb_source_dat_gen.sv
// tb_source_dat_gen: directed vectors for three source_dat_gen builds (default, N_WORDS=3, zero/FFFF seeds)
// with a queue-based scoreboard checked by a separate monitor process.
module tb_source_dat_gen;
    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       load = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [1:0] mq0, mq1, mq2;
    int         vecs = 0;
    int         errs = 0;
    event       ev;

    typedef struct {
        int          k;
        string       nm;
        logic [31:0] dat;
        logic [1:0]  vld;
        logic [1:0]  dn;
        logic [1:0]  mq;
    } exp_t;
    exp_t q[$];

    source_dat_gen_if #(.WIDTH(16), .N_CH(2)) b0 ();
    source_dat_gen_if #(.WIDTH(16), .N_CH(2)) b1 ();
    source_dat_gen_if #(.WIDTH(16), .N_CH(2)) b2 ();

    source_dat_gen u0 (.clk(clk), .rst(rst), .mode(mode), .load(load), .mode_q(mq0), .bus(b0));
    source_dat_gen #(.N_WORDS(3)) u1 (.clk(clk), .rst(rst), .mode(mode), .load(load), .mode_q(mq1), .bus(b1));
    source_dat_gen #(.SEEDS({16'h0000, 16'hFFFF})) u2 (.clk(clk), .rst(rst), .mode(mode), .load(load), .mode_q(mq2), .bus(b2));

    always #5 clk = ~clk;

    function automatic logic [37:0] obs(input int k);
        return (k == 0) ? {b0.dat_o, b0.dat_vld, b0.done, mq0} :
               (k == 1) ? {b1.dat_o, b1.dat_vld, b1.done, mq1} :
                          {b2.dat_o, b2.dat_vld, b2.done, mq2};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [1:0] m);
        mode = m;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic chk(input int k, input string nm, input logic [31:0] d,
                       input logic [1:0] v, input logic [1:0] dn, input logic [1:0] mq);
        exp_t e;
        e.k = k; e.nm = nm; e.dat = d; e.vld = v; e.dn = dn; e.mq = mq;
        q.push_back(e);
        -> ev;
    endtask

    initial forever begin
        @(ev);
        while (q.size() != 0) begin
            exp_t        e;
            logic [37:0] got;
            e   = q.pop_front();
            got = obs(e.k);
            vecs++;
            if (got !== {e.dat, e.vld, e.dn, e.mq}) begin
                errs++;
                $display("FAIL %s u%0d: got dat=%h vld=%b done=%b mode_q=%0d, expected dat=%h vld=%b done=%b mode_q=%0d",
                         e.nm, e.k, got[37:6], got[5:4], got[3:2], got[1:0], e.dat, e.vld, e.dn, e.mq);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        b0.dat_rdy = 2'b11;
        b1.dat_rdy = 2'b00;
        b2.dat_rdy = 2'b00;
        tick();
        tick();
        chk(0, "rst_u0", 32'h5678_1234, 2'b11, 2'b00, 2'd0);
        chk(2, "rst_zero_guard", 32'h0001_FFFF, 2'b11, 2'b00, 2'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk(0, "const", 32'h5678_1234, 2'b11, 2'b00, 2'd0);
        end
        // incr; the handshakes on the load edge must be discarded
        b2.dat_rdy = 2'b01;
        do_load(2'd1);
        chk(0, "load_incr", 32'h5678_1234, 2'b11, 2'b00, 2'd1);
        chk(2, "load_u2", 32'h0001_FFFF, 2'b11, 2'b00, 2'd1);
        tick();
        chk(0, "incr_a", 32'h5679_1235, 2'b11, 2'b00, 2'd1);
        chk(2, "incr_wrap", 32'h0001_0000, 2'b11, 2'b00, 2'd1);
        b2.dat_rdy = 2'b00;
        b0.dat_rdy = 2'b10;
        tick();
        chk(0, "incr_hold", 32'h567A_1235, 2'b11, 2'b00, 2'd1);
        b0.dat_rdy = 2'b11;
        tick();
        chk(0, "incr_b", 32'h567B_1236, 2'b11, 2'b00, 2'd1);
        // LFSR
        do_load(2'd2);
        chk(0, "load_lfsr", 32'h5678_1234, 2'b11, 2'b00, 2'd2);
        tick();
        chk(0, "lfsr_1", 32'h2B3C_091A, 2'b11, 2'b00, 2'd2);
        b0.dat_rdy = 2'b01;
        tick();
        chk(0, "lfsr_2", 32'h2B3C_048D, 2'b11, 2'b00, 2'd2);
        tick();
        chk(0, "lfsr_3", 32'h2B3C_B646, 2'b11, 2'b00, 2'd2);
        // rotate-left, then a mode change without load
        b0.dat_rdy = 2'b11;
        do_load(2'd3);
        chk(0, "load_rotl", 32'h5678_1234, 2'b11, 2'b00, 2'd3);
        tick();
        chk(0, "rotl_1", 32'hACF0_2468, 2'b11, 2'b00, 2'd3);
        tick();
        chk(0, "rotl_2", 32'h59E1_48D0, 2'b11, 2'b00, 2'd3);
        mode = 2'd0;
        tick();
        chk(0, "mode_no_load", 32'hB3C2_91A0, 2'b11, 2'b00, 2'd3);
        // bounded run of 3 words
        b1.dat_rdy = 2'b11;
        do_load(2'd1);
        chk(1, "lim_load", 32'h5678_1234, 2'b11, 2'b00, 2'd1);
        tick();
        chk(1, "lim_1", 32'h5679_1235, 2'b11, 2'b00, 2'd1);
        tick();
        chk(1, "lim_2", 32'h567A_1236, 2'b11, 2'b00, 2'd1);
        tick();
        chk(1, "lim_done", 32'h567A_1236, 2'b00, 2'b11, 2'd1);
        tick();
        tick();
        chk(1, "lim_stay", 32'h567A_1236, 2'b00, 2'b11, 2'd1);
        do_load(2'd1);
        chk(1, "lim_reload", 32'h5678_1234, 2'b11, 2'b00, 2'd1);
        // asynchronous reset mid-run
        tick();
        tick();
        chk(0, "pre_rst", 32'h567A_1236, 2'b11, 2'b00, 2'd1);
        rst = 1'b1;
        #2;
        chk(0, "rst_async_u0", 32'h5678_1234, 2'b11, 2'b00, 2'd0);
        chk(1, "rst_async_u1", 32'h5678_1234, 2'b11, 2'b00, 2'd0);
        tick();
        rst = 1'b0;
        chk(0, "rst_release", 32'h5678_1234, 2'b11, 2'b00, 2'd0);
        tick();
        chk(0, "rst_const", 32'h5678_1234, 2'b11, 2'b00, 2'd0);
        tick();
        chk(1, "rst_cnt_2", 32'h5678_1234, 2'b11, 2'b00, 2'd0);
        tick();
        chk(1, "rst_cnt_done", 32'h5678_1234, 2'b00, 2'b11, 2'd0);
        #1;
        if (q.size() != 0) begin
            errs++;
            $display("FAIL drain: %0d expectations pending, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/source_dat_gen.md
Name: source_dat_gen

Overview:
- Parametrised successor to the fixed master/slave test-word source in the serial-link lab designs.
- Supplies N_CH independent test-data streams, one word per valid/ready handshake.
- Four patterns: constant, increment, Galois LFSR, rotate-left.
- Feeds the link transmitters (master channel 0, slave channel 1 by default); optional word-count limit with done flag for bounded test runs.

Parameters:
- WIDTH, 16, bits per data word (>= 2).
- N_CH, 2, number of channels.
- SEEDS, {16'h5678,16'h1234}, packed N_CH*WIDTH seed vector; channel i = SEEDS[i*WIDTH +: WIDTH].
- POLY, 16'hB400, Galois LFSR feedback mask (WIDTH bits).
- N_WORDS, 0, transfers per run per channel; 0 = unlimited.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  2  pattern select, sampled only on load: 0 const, 1 incr, 2 LFSR, 3 rotl.
- load  input  1  single-cycle strobe: latch mode, reload seeds, restart all channels.
- dat_o  output  N_CH*WIDTH  packed current words; channel i at [i*WIDTH +: WIDTH].
- dat_vld  output  N_CH  per-channel word valid.
- dat_rdy  input  N_CH  per-channel consumer ready.
- done  output  N_CH  per-channel run complete (N_WORDS reached).
- mode_q  output  2  currently active mode.

Behaviour:
- All outputs registered.
- Reset values:
  - dat_o = SEEDS; any channel whose seed is 0 loads 1 instead (LFSR lock-up guard, applied in every mode).
  - dat_vld = all ones; done = 0; mode_q = 0; word counters = 0.
- Per-channel FSM, two states:
  - RUN: dat_vld = 1.
  - DONE: dat_vld = 0, done = 1.
  - Reset and load both enter RUN.
- Transfer: dat_vld[i] & dat_rdy[i] at a rising edge. The word is consumed, and at that edge:
  - Unlimited run, or counter < N_WORDS-1: dat_o[i] <= next(dat_o[i]); counter++.
  - Counter == N_WORDS-1: state <= DONE, done[i] <= 1, dat_o[i] holds the last transferred word.
- next(x):
  - const: x.
  - incr: x+1 modulo 2^WIDTH; 0xFFFF wraps to 0x0000.
  - LFSR: x[0] ? (x>>1)^POLY : (x>>1).
  - rotl: {x[WIDTH-2:0], x[WIDTH-1]}.
- Back-to-back transfers: one word per cycle per channel while rdy is held high. Zero-cycle latency from handshake to next word (next word visible after the same edge).
- Channels are fully independent; simultaneous transfers on several channels are all honoured.
- load: highest priority. At the load edge:
  - mode_q <= mode; all dat_o <= seeds (zero-guarded); counters <= 0; states <= RUN; done <= 0.
  - Any handshake coinciding with load is discarded and not counted.
- DONE exits only via load or rst; dat_rdy is ignored in DONE.
- mode input changes without load have no effect.
- rst asserted mid-run aborts immediately (asynchronous) to reset values; first valid word after release is the seed.
- Counter width: clog2(N_WORDS+1), minimum 1 bit; unused when N_WORDS = 0.

Test Plan:
- Reset, mode 0, rdy = 11 for 5 cycles -> dat_vld = 11 throughout; ch0 stays 0x1234, ch1 stays 0x5678; done = 00.
- load with mode = 1, rdy0 toggling 1,0,1 -> ch0 presents 0x1234, 0x1235 (held for 2 cycles), 0x1236; ch0 stepping is unaffected by ch1 handshakes.
- load with mode = 2, rdy0 = 1 -> ch0 sequence 0x1234, 0x091A, 0x048D, 0xB646; ch1 first step 0x5678 -> 0x2B3C.
- load with mode = 3 -> ch0 sequence 0x1234, 0x2468, 0x48D0; incr from seed 0xFFFF (override build) -> 0x0000.
- N_WORDS = 3, mode 1, rdy = 11:
  - After 3 transfers: done = 11, dat_vld = 00, ch0 holds 0x1236.
  - Further rdy does nothing.
  - load -> vld = 11, done = 00, ch0 = 0x1234.
- load coincident with a handshake, and rst asserted mid-run -> seed reappears, counter = 0, handshake not counted; rst returns all outputs to reset values without waiting for a clock edge.
